// File: rtl/dlx_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dlx_bus_pkg
// Description : Shared types and helpers for the DLX data-side bus router.
//               Contents:
//                 - FSM state encoding (IDLE / WAIT_ACK / RESP)
//                 - default error read-data word
//                 - slave-index extraction from a byte address
// Revision    : 1.0 - initial release
// ============================================================================
package dlx_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    RESP     = 2'd2
  } bus_state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Returns the top sel_bits of an addr_width-bit address. The address is
  // passed zero-extended to 64 bits so one helper serves any ADDR_WIDTH.
  function automatic int unsigned slave_index(input logic [63:0] addr,
                                              input int unsigned addr_width,
                                              input int unsigned sel_bits);
    logic [63:0] shifted;
    logic [63:0] mask;
    shifted = addr >> (addr_width - sel_bits);
    mask    = (64'd1 << sel_bits) - 64'd1;
    return 32'(shifted & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dlx_data_bus_router_if.sv
`default_nettype none
// ============================================================================
// Module      : dlx_data_bus_router_if
// Description : Bundles the processor data port and the per-slave bus of the
//               DLX data bus router.
//               master modport : processor + slave models side
//               slave modport  : router side
// Revision    : 1.0 - initial release
// ============================================================================
interface dlx_data_bus_router_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 4
);

  // Processor side
  logic                             data_rd_en;
  logic                             data_wr_en;
  logic [ADDR_WIDTH-1:0]            data_addr;
  logic [DATA_WIDTH-1:0]            data_write;
  logic [DATA_WIDTH-1:0]            data_read;
  logic                             data_valid;
  logic                             data_busy;
  logic                             bus_err;

  // Slave side
  logic [NUM_SLAVES-1:0]            slv_rd_en;
  logic [NUM_SLAVES-1:0]            slv_wr_en;
  logic [ADDR_WIDTH-1:0]            slv_addr;
  logic [DATA_WIDTH-1:0]            slv_wr_data;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_rd_data;
  logic [NUM_SLAVES-1:0]            slv_ack;

  modport master (
    output data_rd_en, data_wr_en, data_addr, data_write,
    input  data_read, data_valid, data_busy, bus_err,
    input  slv_rd_en, slv_wr_en, slv_addr, slv_wr_data,
    output slv_rd_data, slv_ack
  );

  modport slave (
    input  data_rd_en, data_wr_en, data_addr, data_write,
    output data_read, data_valid, data_busy, bus_err,
    output slv_rd_en, slv_wr_en, slv_addr, slv_wr_data,
    input  slv_rd_data, slv_ack
  );

endinterface
`default_nettype wire

// File: rtl/dlx_data_bus_router_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : bus_timeout_cnt
// Description : Ack-wait watchdog counter for the DLX data bus router.
//               Only instantiated when DATA_BUS_ROUTER_TIMEOUT_EN is defined.
// Ports       : clk, rst_n (async, active-low)
//               clr    - zero the count (entry into the wait state)
//               en     - count one wait cycle
//               expire - high in the TIMEOUT_CYCLES-th enabled cycle
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count starts at 0 in the first wait cycle, so the last permitted wait
  // cycle is the one where the count reads TIMEOUT_CYCLES-1.
  assign expire = en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dlx_data_bus_router.sv
`default_nettype none
// ============================================================================
// Module      : dlx_data_bus_router
// Description : N-way data-side bus router between the DLX data port and
//               NUM_SLAVES memory-mapped slaves. The top SEL_BITS address
//               bits pick the slave; requests complete through a registered
//               strobe/ack handshake with a one-cycle data_valid pulse.
//               Unmapped addresses and simultaneous read+write requests end
//               in an error response (bus_err, ERR_DATA for reads).
// Ports       : clk, rst_n (async, active-low), bus (slave modport of
//               dlx_data_bus_router_if: processor port + slave channels)
// Options     : DATA_BUS_ROUTER_TIMEOUT_EN - ack-wait watchdog
//               (TIMEOUT_CYCLES); absent by default.
// Revision    : 1.0 - initial release
// ============================================================================
module dlx_data_bus_router
  import dlx_bus_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    NUM_SLAVES     = 4,
  parameter int                    SEL_BITS       = 2,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dlx_data_bus_router_if.slave  bus
);

  // Clears the select bits so slaves see a local address.
  localparam logic [ADDR_WIDTH-1:0] ADDR_KEEP = {ADDR_WIDTH{1'b1}} >> SEL_BITS;

  bus_state_e            state_q,       state_d;
  logic [SEL_BITS-1:0]   idx_q,         idx_d;
  logic                  is_rd_q,       is_rd_d;
  logic [DATA_WIDTH-1:0] data_read_q,   data_read_d;
  logic                  data_valid_q,  data_valid_d;
  logic                  data_busy_q,   data_busy_d;
  logic                  bus_err_q,     bus_err_d;
  logic [NUM_SLAVES-1:0] slv_rd_en_q,   slv_rd_en_d;
  logic [NUM_SLAVES-1:0] slv_wr_en_q,   slv_wr_en_d;
  logic [ADDR_WIDTH-1:0] slv_addr_q,    slv_addr_d;
  logic [DATA_WIDTH-1:0] slv_wr_data_q, slv_wr_data_d;

  logic                  req_idx_valid;
  logic [SEL_BITS-1:0]   req_idx;
  logic                  timeout_expire;

  assign req_idx       = SEL_BITS'(slave_index(64'(bus.data_addr), ADDR_WIDTH, SEL_BITS));
  assign req_idx_valid = int'(req_idx) < NUM_SLAVES;

`ifdef DATA_BUS_ROUTER_TIMEOUT_EN
  logic to_clr;
  logic to_en;

  assign to_clr = (state_q != WAIT_ACK) && (state_d == WAIT_ACK);
  assign to_en  = (state_q == WAIT_ACK);

  bus_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (to_clr),
    .en     (to_en),
    .expire (timeout_expire)
  );
`else
  // No watchdog: the ack wait is unbounded. The comparison is constant-false
  // and keeps TIMEOUT_CYCLES referenced in this build.
  assign timeout_expire = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    is_rd_d       = is_rd_q;
    data_read_d   = data_read_q;
    data_valid_d  = 1'b0;
    data_busy_d   = data_busy_q;
    bus_err_d     = 1'b0;
    slv_addr_d    = slv_addr_q;
    slv_wr_data_d = slv_wr_data_q;
    slv_rd_en_d   = '0;
    slv_wr_en_d   = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.data_rd_en || bus.data_wr_en) begin
          data_busy_d   = 1'b1;
          idx_d         = req_idx;
          is_rd_d       = bus.data_rd_en;
          slv_addr_d    = bus.data_addr & ADDR_KEEP;
          slv_wr_data_d = bus.data_write;
          if ((bus.data_rd_en && bus.data_wr_en) || !req_idx_valid) begin
            state_d      = RESP;
            data_valid_d = 1'b1;
            bus_err_d    = 1'b1;
            if (bus.data_rd_en) begin
              data_read_d = ERR_DATA;
            end
          end else begin
            state_d = WAIT_ACK;
          end
        end
      end

      WAIT_ACK: begin
        // Only the selected slave's ack counts; an ack wins over a
        // simultaneous watchdog expiry.
        if (bus.slv_ack[idx_q]) begin
          state_d      = RESP;
          data_valid_d = 1'b1;
          if (is_rd_q) begin
            data_read_d = bus.slv_rd_data[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
          end
        end else if (timeout_expire) begin
          state_d      = RESP;
          data_valid_d = 1'b1;
          bus_err_d    = 1'b1;
          if (is_rd_q) begin
            data_read_d = ERR_DATA;
          end
        end
      end

      RESP: begin
        state_d     = IDLE;
        data_busy_d = 1'b0;
      end

      default: begin
        state_d     = IDLE;
        data_busy_d = 1'b0;
      end
    endcase

    // Strobes are registered: high for every cycle spent in WAIT_ACK.
    if (state_d == WAIT_ACK) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        slv_rd_en_d[i] =  is_rd_d && (int'(idx_d) == i);
        slv_wr_en_d[i] = !is_rd_d && (int'(idx_d) == i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      is_rd_q       <= 1'b0;
      data_read_q   <= '0;
      data_valid_q  <= 1'b0;
      data_busy_q   <= 1'b0;
      bus_err_q     <= 1'b0;
      slv_rd_en_q   <= '0;
      slv_wr_en_q   <= '0;
      slv_addr_q    <= '0;
      slv_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      is_rd_q       <= is_rd_d;
      data_read_q   <= data_read_d;
      data_valid_q  <= data_valid_d;
      data_busy_q   <= data_busy_d;
      bus_err_q     <= bus_err_d;
      slv_rd_en_q   <= slv_rd_en_d;
      slv_wr_en_q   <= slv_wr_en_d;
      slv_addr_q    <= slv_addr_d;
      slv_wr_data_q <= slv_wr_data_d;
    end
  end

  assign bus.data_read   = data_read_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.data_busy   = data_busy_q;
  assign bus.bus_err     = bus_err_q;
  assign bus.slv_rd_en   = slv_rd_en_q;
  assign bus.slv_wr_en   = slv_wr_en_q;
  assign bus.slv_addr    = slv_addr_q;
  assign bus.slv_wr_data = slv_wr_data_q;

endmodule
`default_nettype wire

// File: doc/dlx_data_bus_router.md
# dlx_data_bus_router

Parametrised data-side bus router between the DLX processor data port and NUM_SLAVES memory-mapped slaves (SDRAM controller, GPIO, future peripherals). It generalises the fixed two-way SDRAM/GPIO write split into an N-way address decoder for both reads and writes. Each transaction uses a registered request/acknowledge handshake, a stall output for the processor, and unmapped-address error reporting. An optional timeout watchdog can be compiled in.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, byte address width
- NUM_SLAVES, 4, slave channels (1..2^SEL_BITS)
- SEL_BITS, 2, top address bits used as slave index
- TIMEOUT_CYCLES, 255, ack wait limit (only used with timeout compiled in)
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- data_rd_en  in  1  processor read request
- data_wr_en  in  1  processor write request
- data_addr  in  ADDR_WIDTH  request address
- data_write  in  DATA_WIDTH  write data
- data_read  out  DATA_WIDTH  registered read data
- data_valid  out  1  one-cycle completion pulse (reads and writes)
- data_busy  out  1  transaction pending; processor stalls
- bus_err  out  1  one-cycle error pulse, coincident with data_valid
- slv_rd_en  out  NUM_SLAVES  per-slave read strobe
- slv_wr_en  out  NUM_SLAVES  per-slave write strobe
- slv_addr  out  ADDR_WIDTH  shared address, select bits forced to 0
- slv_wr_data  out  DATA_WIDTH  shared write data
- slv_rd_data  in  NUM_SLAVES*DATA_WIDTH  flattened read data; slave i at [i*DATA_WIDTH +: DATA_WIDTH]
- slv_ack  in  NUM_SLAVES  per-slave completion

## Operation
- FSM states are IDLE, WAIT_ACK and RESP.
- IDLE:
  - On a request, capture the address, write data, direction and index = data_addr[ADDR_WIDTH-1 -: SEL_BITS].
  - Assert data_busy.
  - If index < NUM_SLAVES, go to WAIT_ACK. Otherwise go to RESP with error.
- Simultaneous data_rd_en and data_wr_en is treated as an error: go to RESP, no slave strobe.
- WAIT_ACK:
  - The strobe for the selected slave is held high. All other strobes are low.
  - When slv_ack[index] is sampled high, capture slv_rd_data[index] (reads only) and go to RESP.
  - Acks from non-selected slaves are ignored.
- RESP:
  - data_valid = 1 for exactly one cycle. On error, bus_err = 1 as well.
  - For a read, data_read takes the captured data, or ERR_DATA on error. A write leaves data_read unchanged.
  - data_busy drops in this cycle; the FSM returns to IDLE.
- Requests arriving while data_busy is high are ignored. The processor must not issue one.
- An ack arriving in IDLE or RESP (stale or late) is ignored.
- Reset values: data_read = 0, data_valid = 0, data_busy = 0, bus_err = 0, all slv_* outputs = 0, state = IDLE.
- Reset asserted mid-transaction drops all strobes immediately (asynchronously). No completion pulse follows.

## Timing
- All outputs are registered.
- Request sampled at edge 0 → strobe high after edge 0 (cycle 1).
- Slave ack in cycle k → data_valid/data_read in cycle k+1 → back in IDLE in cycle k+2.
- Minimum latency: an ack in cycle 1 gives data_valid in cycle 2.
- Unmapped or dual-request error: data_valid/bus_err in cycle 1, no strobe.
- A new request is accepted in the cycle after data_valid.

## Configuration
- DATA_BUS_ROUTER_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT_ACK.
  - If the ack is still absent after TIMEOUT_CYCLES cycles in WAIT_ACK, strobes drop and the FSM goes to RESP with bus_err.
  - A read returns ERR_DATA.
- Undefined: WAIT_ACK waits indefinitely, bus_err arises only from decode errors, and TIMEOUT_CYCLES is unused.

## Structure
- Package dlx_bus_pkg holds:
  - the state enum (IDLE/WAIT_ACK/RESP)
  - the default ERR_DATA constant
  - the slave-index extract function
- One sub-module, bus_timeout_cnt: clear/enable inputs, expire output, width $clog2(TIMEOUT_CYCLES+1). Instantiated only under the macro.

## Test plan
- Read to slave 2 (addr 32'h8000_0010, NUM_SLAVES=4), ack in cycle 3 with data 32'h1234_5678 → slv_rd_en = 4'b0100 in cycles 1–3, slv_addr = 32'h0000_0010, data_valid and data_read = 32'h1234_5678 in cycle 4.
- Write to slave 0 with data 32'hA5A5_A5A5, immediate ack → slv_wr_en[0] only in cycle 1, slv_wr_data = 32'hA5A5_A5A5, data_valid in cycle 2, data_read unchanged.
- NUM_SLAVES=3, read at addr 32'hC000_0000 → no strobe, data_valid/bus_err in cycle 1, data_read = 32'hDEAD_BEEF.
- Macro defined, TIMEOUT_CYCLES=8, no ack → strobe low after 8 WAIT_ACK cycles, bus_err pulse, data_busy low next cycle; a late ack afterwards is ignored.
- rst_n low during WAIT_ACK → strobes and data_busy go to 0 asynchronously, no data_valid; a fresh read after reset completes normally.
- data_rd_en and data_wr_en high together → bus_err in cycle 1, no slave strobe.
